// File: rtl/taillight_pkg.sv
// rtl/taillight_pkg.sv - state encoding and lamp patterns for taillight_sched
package taillight_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    L1   = 4'd1,
    L2   = 4'd2,
    L3   = 4'd3,
    R1   = 4'd4,
    R2   = 4'd5,
    R3   = 4'd6,
    H1   = 4'd7,
    H2   = 4'd8,
    H3   = 4'd9
  } tl_state_t;

  // {left[5:3], right[2:0]}; innermost lamps are bit 3 and bit 2
  localparam logic [5:0] PAT_IDLE = 6'b000_000;
  localparam logic [5:0] PAT_L1   = 6'b001_000;
  localparam logic [5:0] PAT_L2   = 6'b011_000;
  localparam logic [5:0] PAT_L3   = 6'b111_000;
  localparam logic [5:0] PAT_R1   = 6'b000_100;
  localparam logic [5:0] PAT_R2   = 6'b000_110;
  localparam logic [5:0] PAT_R3   = 6'b000_111;
  localparam logic [5:0] PAT_H1   = 6'b001_100;
  localparam logic [5:0] PAT_H2   = 6'b011_110;
  localparam logic [5:0] PAT_H3   = 6'b111_111;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler, one-cycle tick every DIV_MAX+1 clocks
module tick_gen #(
  parameter int unsigned DIV_W   = 24,
  parameter int unsigned DIV_MAX = 12_499_999
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam logic [DIV_W-1:0] TERM = DIV_W'(DIV_MAX);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == TERM);
    cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/taillight_sched.sv
// rtl/taillight_sched.sv - tail-light sequencer: switch sync, arbitration, pattern decode
// Optional brake overlay enabled by defining TAILLIGHT_BRAKE_EN.
module taillight_sched
  import taillight_pkg::*;
#(
  parameter int unsigned DIV_W   = 24,
  parameter int unsigned DIV_MAX = 12_499_999
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  input  logic       brake,
  output logic [5:0] lights,
  output logic       busy,
  output logic       tick
);

  tick_gen #(
    .DIV_W  (DIV_W),
    .DIV_MAX(DIV_MAX)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  // {hazard, right, left} through a two-flop synchronizer
  logic [2:0] sw_meta_q, sw_meta_d, sw_s_q, sw_s_d;
  logic       left_s, right_s, hazard_s;
  logic       brake_s;

  always_comb begin
    sw_meta_d = {hazard, right, left};
    sw_s_d    = sw_meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta_q <= '0;
      sw_s_q    <= '0;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_s_q    <= sw_s_d;
    end
  end

  assign left_s   = sw_s_q[0];
  assign right_s  = sw_s_q[1];
  assign hazard_s = sw_s_q[2];

`ifdef TAILLIGHT_BRAKE_EN
  logic brake_meta_q, brake_meta_d, brake_s_q, brake_s_d;

  always_comb begin
    brake_meta_d = brake;
    brake_s_d    = brake_meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      brake_meta_q <= 1'b0;
      brake_s_q    <= 1'b0;
    end else begin
      brake_meta_q <= brake_meta_d;
      brake_s_q    <= brake_s_d;
    end
  end

  assign brake_s = brake_s_q;
`else
  logic brake_unused;
  assign brake_unused = brake;
  assign brake_s      = 1'b0;
`endif

  tl_state_t state_q, state_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (tick) begin
        if (hazard_s || (left_s && right_s)) state_d = H1;
        else if (left_s)                     state_d = L1;
        else if (right_s)                    state_d = R1;
      end
      L1:   if (tick) state_d = hazard_s ? H1 : L2;
      L2:   if (tick) state_d = hazard_s ? H1 : L3;
      L3:   if (tick) state_d = hazard_s ? H1 : IDLE;
      R1:   if (tick) state_d = hazard_s ? H1 : R2;
      R2:   if (tick) state_d = hazard_s ? H1 : R3;
      R3:   if (tick) state_d = hazard_s ? H1 : IDLE;
      H1:   if (tick) state_d = H2;
      H2:   if (tick) state_d = H3;
      H3:   if (tick) state_d = IDLE;
      // corrupted encodings recover immediately rather than waiting for a tick
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lights = PAT_IDLE;
    case (state_q)
      L1: lights = PAT_L1;
      L2: lights = PAT_L2;
      L3: lights = PAT_L3;
      R1: lights = PAT_R1;
      R2: lights = PAT_R2;
      R3: lights = PAT_R3;
      H1: lights = PAT_H1;
      H2: lights = PAT_H2;
      H3: lights = PAT_H3;
      default: lights = PAT_IDLE;
    endcase
    if (brake_s) begin
      case (state_q)
        IDLE:       lights      = 6'b111_111;
        L1, L2, L3: lights[2:0] = 3'b111;
        R1, R2, R3: lights[5:3] = 3'b111;
        default:    ;
      endcase
    end
    busy = (state_q != IDLE);
  end

endmodule

// File: doc/taillight_sched.md
# taillight_sched

Sequencing controller for the six-lamp tail-light array. Synchronizes the driver switches (left, right, hazard, brake), derives a slow step tick from the system clock, arbitrates between competing requests, and steps the lamp patterns one phase per tick. Sits between the board switch inputs and the lamp output pins. It replaces direct wiring of raw switches into the light pattern FSM.

## Interface
- `DIV_W`, default 24: prescaler counter width.
- `DIV_MAX`, default 12_499_999: terminal count. Gives a tick every DIV_MAX+1 cycles, which is 4 Hz at 50 MHz. Must fit in DIV_W bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `left`  in  1  left-turn switch; asynchronous.
- `right`  in  1  right-turn switch; asynchronous.
- `hazard`  in  1  hazard switch; asynchronous.
- `brake`  in  1  brake switch; asynchronous.
- `lights`  out  6  lamps. [5:3] is left (bit 3 innermost). [2:0] is right (bit 2 innermost).
- `busy`  out  1  high whenever the state is not IDLE.
- `tick`  out  1  one-cycle step strobe, for debug and bench sync.

## Operation
- **Input synchronizers:** every switch input passes through a 2-flop synchronizer. All decisions use the synced copies (`*_s`).
- **Prescaler:**
  - Free-running counter, 0..DIV_MAX.
  - `tick` is 1 in the cycle where count == DIV_MAX; the counter then wraps to 0.
  - Never paused or reloaded by requests.
- **States:** IDLE, L1, L2, L3, R1, R2, R3, H1, H2, H3. The state advances only in a cycle with tick=1 and holds otherwise.
- **Arbitration in IDLE on tick (priority order):**
  - hazard_s, or left_s & right_s → H1
  - else left_s → L1
  - else right_s → R1
  - else stay in IDLE
- **Sequences:**
  - L1→L2→L3→IDLE, R1→R2→R3→IDLE, H1→H2→H3→IDLE.
  - Every sequence returns through IDLE, so there is always one dark tick between sequences.
- **Preemption:**
  - In any L or R state, a tick with hazard_s=1 goes to H1.
  - A turn request never preempts another sequence.
  - Dropping a switch mid-sequence does not abort the sequence.
- **Patterns (Moore decode of the state register):**
  - IDLE: 000_000
  - L1/L2/L3: 001_000, 011_000, 111_000
  - R1/R2/R3: 000_100, 000_110, 000_111
  - H1/H2/H3: 001_100, 011_110, 111_111
- **Brake overlay:** see Configuration.
- **Illegal state encoding:** goes to IDLE on the next clock, without waiting for a tick. Lights decode to 000_000 in that cycle.

## Timing
- **Reset:**
  - Asserting reset_n low forces, immediately (asynchronously): state=IDLE, prescaler=0, synchronizer flops=0, lights=000_000, busy=0, tick=0.
  - Reset mid-sequence drops the sequence with no resumption.
  - After deassertion, the first tick occurs DIV_MAX+1 cycles later.
- **Switch latency:** 2 cycles to the synced copy. The switch is then acted on at the next tick.
- **Output latency:** `lights` and `busy` change the cycle after the tick cycle (state-register edge). `lights` is combinational from the state register and brake_s only, with no path from the raw inputs.
- **Sequence length:** one full turn or hazard sequence occupies 3 ticks, plus 1 IDLE tick.
- **Simultaneous left, right and hazard:** H1.
- **Switch deasserted before the next tick:** ignored.

## Configuration
- `TAILLIGHT_BRAKE_EN` defined:
  - While brake_s=1, any side not part of the active sequence is forced to 111.
  - In IDLE, brake_s=1 gives 111_111.
  - No effect during H states.
  - Applies from the cycle after brake_s rises (combinational on brake_s). It does not wait for a tick.
- `TAILLIGHT_BRAKE_EN` undefined:
  - The `brake` port remains but is unused, and its synchronizer is omitted.
  - Lights are the pure pattern decode.

## Structure
- **`taillight_pkg`:** the state enum `tl_state_t` (logic [3:0], IDLE=0) and the ten 6-bit pattern constants.
- **Sub-module `tick_gen`:** parameters DIV_W and DIV_MAX; ports clk, reset_n, tick. Holds the prescaler.
- **Top level:** synchronizers, FSM and output decode.

## Test plan
All scenarios use DIV_MAX=3, which gives a tick every 4 cycles.
- **Reset hold:** reset_n=0 with all switches high → lights=000_000, busy=0, tick=0 throughout. Release reset → first tick exactly 4 cycles later.
- **Left turn:** left=1 held → lights 001_000, 011_000, 111_000, 000_000 on successive ticks, then repeat. busy drops only in IDLE.
- **Right-to-hazard preemption:** right=1; after R2 appears, hazard=1 → next tick gives 001_100 (H1), then H2, H3, IDLE.
- **Both turns:** left=right=1 from IDLE → H1..H3 patterns, identical to the hazard sequence.
- **Brake, with TAILLIGHT_BRAKE_EN:**
  - brake=1 in IDLE → 111_111 within 3 cycles, with no tick needed.
  - With left also set → L1 shows 001_111.
  - Without the macro → 000_000 and 001_000 respectively.
- **Async reset mid-sequence:** pulse reset_n low during L2 (mid-tick) → lights=000_000 in the same cycle, state IDLE, prescaler restarts from 0.
